// File: rtl/fifo_pkg.sv
// Shared definitions for FIFO-side controllers.
// Holds the read-side FSM state encoding so other controllers reuse the same values.
package fifo_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } fifo_rd_state_e;

endpackage

// File: rtl/burst_out_reg.sv
// Output register stage for the burst reader: one data+last beat with valid/ready.
// A load always wins over a same-cycle accept, which gives back-to-back beats.
module burst_out_reg #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_last,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    output logic                  o_last
);

    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid;
    logic                  r_last;

    // Capture a beat on load; drop valid on accept; otherwise hold data and last stable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else if (i_load) begin
            r_data  <= i_data;
            r_valid <= 1'b1;
            r_last  <= i_last;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;
    assign o_last  = r_last;

endmodule

// File: rtl/fifo_burst_reader.sv
// Burst reader: waits for BURST_LEN words in the upstream sync FIFO, then pops them
// one per cycle into a registered valid/ready output, flagging the final beat.
// Optional feature macro BURST_TIMEOUT_EN: flush a partial burst after TIMEOUT_CYC
// idle cycles with words waiting below the threshold.
module fifo_burst_reader
    import fifo_pkg::*;
#(
    parameter int  DATA_WIDTH  = 32,
    parameter int  FIFO_DEPTH  = 32,
    parameter int  BURST_LEN   = 8,
    parameter int  TIMEOUT_CYC = 64,
    localparam int ADDR_WIDTH  = $clog2(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] fifo_data_i,
    input  logic                  fifo_empty_i,
    input  logic [ADDR_WIDTH:0]   fifo_counter_i,
    output logic                  fifo_rd_valid_o,
    output logic [DATA_WIDTH-1:0] fwd_data_o,
    output logic                  fwd_valid_o,
    output logic                  fwd_last_o,
    input  logic                  fwd_ready_i,
    output logic                  busy_o
);

    localparam int REM_W = $clog2(BURST_LEN + 1);
    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0] BURST_LEN_C = CNT_W'(BURST_LEN);
    localparam logic [REM_W-1:0] BURST_LEN_R = REM_W'(BURST_LEN);

    if (BURST_LEN < 1 || BURST_LEN > FIFO_DEPTH) begin : g_bad_burst_len
        $error("BURST_LEN must be in 1..FIFO_DEPTH");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 1");
    end

    fifo_rd_state_e   r_state;
    logic [REM_W-1:0] r_remaining;
    logic             w_pop;
    logic             w_last_beat;
    logic             w_fwd_valid;

`ifdef BURST_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
    logic [TO_W-1:0] r_timeout;
`endif

    // Pop only while streaming, with words left in the burst and room in the output stage.
    always_comb begin
        w_pop = (r_state == STREAM) && !fifo_empty_i && (r_remaining != '0) &&
                (!w_fwd_valid || fwd_ready_i);
        w_last_beat = (r_remaining == REM_W'(1));
    end

    // Burst FSM: start on threshold (or timeout), count pops down, return to IDLE on the last.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_remaining <= '0;
`ifdef BURST_TIMEOUT_EN
            r_timeout   <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (fifo_counter_i >= BURST_LEN_C) begin
                        r_state     <= STREAM;
                        r_remaining <= BURST_LEN_R;
`ifdef BURST_TIMEOUT_EN
                        r_timeout   <= '0;
                    end else if (fifo_counter_i != '0) begin
                        if (r_timeout == TO_LAST) begin
                            // Partial burst: take whatever is waiting right now.
                            r_state     <= STREAM;
                            r_remaining <= fifo_counter_i[REM_W-1:0];
                            r_timeout   <= '0;
                        end else begin
                            r_timeout <= r_timeout + TO_W'(1);
                        end
                    end else begin
                        r_timeout <= '0;
`endif
                    end
                end
                STREAM: begin
`ifdef BURST_TIMEOUT_EN
                    r_timeout <= '0;
`endif
                    if (w_pop) begin
                        r_remaining <= r_remaining - REM_W'(1);
                        if (w_last_beat) begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    burst_out_reg #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out_reg (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_pop),
        .i_data  (fifo_data_i),
        .i_last  (w_last_beat),
        .i_ready (fwd_ready_i),
        .o_data  (fwd_data_o),
        .o_valid (w_fwd_valid),
        .o_last  (fwd_last_o)
    );

    assign fwd_valid_o     = w_fwd_valid;
    assign fifo_rd_valid_o = w_pop;
    assign busy_o          = (r_state != IDLE) || w_fwd_valid;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: a queue-based FIFO stub, a behavioural burst model
// checked every cycle, directed scenarios with literal expectations, and random traffic.
module tb_fifo_burst_reader;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int BL    = 4;
    localparam int TO    = 16;
    localparam int AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] fifo_data = '0;
    logic          fifo_empty = 1'b1;
    logic [AW:0]   fifo_count = '0;
    logic          rd;
    logic [DW-1:0] fwd_data;
    logic          fwd_valid, fwd_last, busy;
    logic          fwd_ready = 1'b1;

    fifo_burst_reader #(
        .DATA_WIDTH  (DW),
        .FIFO_DEPTH  (DEPTH),
        .BURST_LEN   (BL),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .fifo_data_i     (fifo_data),
        .fifo_empty_i    (fifo_empty),
        .fifo_counter_i  (fifo_count),
        .fifo_rd_valid_o (rd),
        .fwd_data_o      (fwd_data),
        .fwd_valid_o     (fwd_valid),
        .fwd_last_o      (fwd_last),
        .fwd_ready_i     (fwd_ready),
        .busy_o          (busy)
    );

    always #5 clk = ~clk;

    // FIFO stub and pending writes
    logic [DW-1:0] q[$];
    logic [DW-1:0] pend[$];
    bit            hold_empty = 1'b0;

    // Behavioural model: is a burst open, how many words it still owes, and the held beat
    bit            m_stream = 1'b0;
    int            m_left   = 0;
    int            m_wait   = 0;
    bit            m_v      = 1'b0;
    bit            m_l      = 1'b0;
    logic [DW-1:0] m_d      = '0;

    // Observation logs
    logic [DW:0] obs[$];
    int          pop_cyc[$];
    int          busy_cnt = 0;
    int          cyc      = 0;
    int          checks   = 0;
    int          errors   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit model_pop();
        return m_stream && !fifo_empty && (m_left > 0) && (!m_v || fwd_ready);
    endfunction

    task automatic drive_fifo();
        fifo_empty = (q.size() == 0) || hold_empty;
        fifo_count = (AW + 1)'(q.size());
        fifo_data  = (q.size() > 0) ? q[0] : '0;
    endtask

    // Model + FIFO update just after each rising edge, from the inputs seen at that edge.
    always @(posedge clk) begin
        bit pop;
        bit was_stream;
        int cnt;
        #1;
        cyc++;
        if (rst) begin
            m_stream = 0; m_left = 0; m_wait = 0; m_v = 0; m_l = 0; m_d = '0;
        end else begin
            pop        = model_pop();
            was_stream = m_stream;
            cnt        = q.size();
            if (pop) begin
                m_v = 1;
                m_d = q[0];
                m_l = (m_left == 1);
                m_left--;
                if (m_left == 0) m_stream = 0;
                void'(q.pop_front());
            end else if (m_v && fwd_ready) begin
                m_v = 0;
            end
            if (!was_stream) begin
                if (cnt >= BL) begin
                    m_stream = 1; m_left = BL; m_wait = 0;
                end else if (cnt > 0) begin
                    m_wait++;
`ifdef BURST_TIMEOUT_EN
                    if (m_wait == TO) begin
                        m_stream = 1; m_left = cnt; m_wait = 0;
                    end
`endif
                end else begin
                    m_wait = 0;
                end
            end else begin
                m_wait = 0;
            end
        end
        while (pend.size() > 0) q.push_back(pend.pop_front());
        drive_fifo();
    end

    // Single compare process: DUT outputs against the model, every cycle.
    always @(negedge clk) begin
        if (rst) begin
            check("rst_rd", rd, 0);
            check("rst_valid", fwd_valid, 0);
            check("rst_last", fwd_last, 0);
            check("rst_data", fwd_data, 0);
            check("rst_busy", busy, 0);
        end else begin
            check("rd_valid", rd, model_pop());
            check("fwd_valid", fwd_valid, m_v);
            check("fwd_data", fwd_data, m_d);
            check("fwd_last", fwd_last, m_l);
            check("busy", busy, m_stream || m_v);
            if (rd) pop_cyc.push_back(cyc);
            if (fwd_valid && fwd_ready) obs.push_back({fwd_last, fwd_data});
            if (busy) busy_cnt++;
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #3;
        end
    endtask

    task automatic set_hold(input bit v);
        hold_empty = v;
        drive_fifo();
    endtask

    task automatic clear_logs();
        obs.delete();
        pop_cyc.delete();
        busy_cnt = 0;
    endtask

    task automatic push_run(input logic [DW-1:0] base, input int n);
        for (int i = 0; i < n; i++) pend.push_back(base + DW'(i));
    endtask

    // Accepted beats must be base, base+1, ... with last on every BL-th beat.
    task automatic check_stream(input string name, input logic [DW-1:0] base, input int n);
        logic [DW:0] e;
        check({name, "_count"}, obs.size(), n);
        for (int i = 0; i < n && i < obs.size(); i++) begin
            e = {(i % BL == BL - 1), base + DW'(i)};
            check($sformatf("%s_beat%0d", name, i), obs[i], e);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        drive_fifo();
        step(3);
        check("init_valid", fwd_valid, 0);
        check("init_busy", busy, 0);
        check("init_rd", rd, 0);
        rst = 1'b0;
        step(2);

`ifdef BURST_TIMEOUT_EN
        // Two words below threshold are flushed as a partial burst after the timeout.
        clear_logs();
        push_run(32'h60, 2);
        c0 = cyc + 1;
        step(25);
        check("to_pops", pop_cyc.size(), 2);
        if (pop_cyc.size() > 0) check("to_delay", pop_cyc[0] - c0, 16);
        check("to_count", obs.size(), 2);
        if (obs.size() == 2) begin
            check("to_beat0", obs[0], {1'b0, 32'h60});
            check("to_beat1", obs[1], {1'b1, 32'h61});
        end
`endif

        // Full burst at full rate: four consecutive pops and beats, last on the fourth.
        clear_logs();
        fwd_ready = 1'b1;
        push_run(32'hA0, 4);
        step(12);
        check_stream("b4", 32'hA0, 4);
        check("b4_pops", pop_cyc.size(), 4);
        if (pop_cyc.size() == 4) check("b4_pop_span", pop_cyc[3] - pop_cyc[0], 3);

`ifndef BURST_TIMEOUT_EN
        // Below threshold: nothing moves for 200 cycles, then one more word completes it.
        clear_logs();
        push_run(32'hB0, 3);
        step(200);
        check("short_pops", pop_cyc.size(), 0);
        check("short_busy", busy_cnt, 0);
        push_run(32'hB3, 1);
        step(12);
        check_stream("short_fill", 32'hB0, 4);
`endif

        // Stalling consumer: ready 1,0,0,1 repeating over two bursts.
        clear_logs();
        push_run(32'hC0, 8);
        for (int i = 0; i < 48; i++) begin
            fwd_ready = (i % 4 == 0) || (i % 4 == 3);
            step(1);
        end
        fwd_ready = 1'b1;
        step(4);
        check_stream("stall", 32'hC0, 8);

        // Reset while the third beat is held.
        clear_logs();
        fwd_ready = 1'b1;
        push_run(32'hD0, 4);
        for (int i = 0; i < 30 && obs.size() < 2; i++) step(1);
        fwd_ready = 1'b0;
        check("rst_mid_seen", obs.size(), 2);
        step(2);
        check("held_valid", fwd_valid, 1);
        check("held_data", fwd_data, 32'hD2);
        rst = 1'b1;
        #1;
        check("async_valid", fwd_valid, 0);
        check("async_data", fwd_data, 0);
        check("async_busy", busy, 0);
        step(2);
        rst = 1'b0;
        fwd_ready = 1'b1;
        clear_logs();
`ifndef BURST_TIMEOUT_EN
        step(30);
        check("post_rst_pops", pop_cyc.size(), 0);
        push_run(32'hD4, 3);
        step(12);
        check_stream("post_rst", 32'hD3, 4);
`else
        step(30);
        push_run(32'hD4, 3);
        step(40);
`endif

        // Empty FIFO mid-burst: stall in STREAM, then resume to the last beat.
        clear_logs();
        fwd_ready = 1'b1;
        push_run(32'hF0, 4);
        for (int i = 0; i < 20 && pop_cyc.size() < 2; i++) step(1);
        set_hold(1'b1);
        check("gap_reached", pop_cyc.size(), 2);
        step(1);
        busy_cnt = 0;
        step(6);
        check("gap_busy", busy_cnt, 6);
        check("gap_pops", pop_cyc.size(), 2);
        set_hold(1'b0);
        step(8);
        check_stream("gap", 32'hF0, 4);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            fwd_ready = ($urandom_range(0, 3) != 0);
            if ((q.size() + pend.size() < DEPTH) && ($urandom_range(0, 2) == 0))
                pend.push_back($urandom);
            set_hold($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 599) == 0) begin
                rst = 1'b1;
                step(1);
                rst = 1'b0;
            end
            step(1);
        end
        fwd_ready = 1'b1;
        set_hold(1'b0);
        step(40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
